// File: rtl/spimem_arbiter.sv
// rtl/spimem_arbiter.sv - two-requester (video priority, CPU anti-starvation) arbiter for the SPI/QPI RAM read master
module spimem_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        vid_do_read,
    input  logic [23:0] vid_addr,
    output logic        vid_next_byte,
    output logic [31:0] vid_rdata,
    output logic        vid_is_idle,
    input  logic        cpu_do_read,
    input  logic [23:0] cpu_addr,
    output logic        cpu_next_byte,
    output logic [31:0] cpu_rdata,
    output logic        cpu_is_idle,
    output logic        m_do_read,
    output logic [23:0] m_addr,
    input  logic        m_next_byte,
    input  logic [31:0] m_rdata,
    input  logic        m_is_idle,
    output logic        grant_vid,
    output logic        grant_cpu
);

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t             state, state_nxt;
    logic               owner_cpu, owner_cpu_nxt;
    logic               m_do_read_nxt;
    logic [23:0]        m_addr_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic               pick_cpu;
    logic               owner_req;
    logic               busy;

    assign owner_req = owner_cpu ? cpu_do_read : vid_do_read;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            owner_cpu <= 1'b0;
            m_do_read <= 1'b0;
            m_addr    <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            owner_cpu <= owner_cpu_nxt;
            m_do_read <= m_do_read_nxt;
            m_addr    <= m_addr_nxt;
            cnt       <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        owner_cpu_nxt = owner_cpu;
        m_do_read_nxt = m_do_read;
        m_addr_nxt    = m_addr;
        cnt_nxt       = cnt;
        pick_cpu      = 1'b0;
        case (state)
            IDLE: begin
                m_do_read_nxt = 1'b0;
                if (m_is_idle && (vid_do_read || cpu_do_read)) begin
                    // Video wins ties unless the CPU has already lost STARVE_LIMIT in a row
                    pick_cpu      = cpu_do_read && (!vid_do_read || cnt == LIMIT);
                    state_nxt     = BURST;
                    owner_cpu_nxt = pick_cpu;
                    m_do_read_nxt = 1'b1;
                    m_addr_nxt    = pick_cpu ? cpu_addr : vid_addr;
                    if (pick_cpu || !cpu_do_read)
                        cnt_nxt = '0;
                    else if (cnt != LIMIT)
                        cnt_nxt = cnt + CNT_W'(1);
                end
            end
            BURST: begin
                m_do_read_nxt = owner_req;
                if (!owner_req)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                m_do_read_nxt = 1'b0;
                if (m_is_idle)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt     = IDLE;
                m_do_read_nxt = 1'b0;
            end
        endcase
    end

    // Routing follows the owner through DRAIN so a byte landing on release is not lost
    assign grant_vid     = busy && !owner_cpu;
    assign grant_cpu     = busy && owner_cpu;
    assign vid_rdata     = m_rdata;
    assign cpu_rdata     = m_rdata;
    assign vid_next_byte = grant_vid && m_next_byte;
    assign cpu_next_byte = grant_cpu && m_next_byte;
    assign vid_is_idle   = busy ? (grant_vid && m_is_idle) : m_is_idle;
    assign cpu_is_idle   = busy ? (grant_cpu && m_is_idle) : m_is_idle;

endmodule

// File: tb/tb_spimem_arbiter.sv
// tb/tb_spimem_arbiter.sv - directed self-checking bench for spimem_arbiter
module tb_spimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        vid_do_read, cpu_do_read;
    logic [23:0] vid_addr, cpu_addr;
    logic        vid_next_byte, cpu_next_byte, vid_is_idle, cpu_is_idle;
    logic [31:0] vid_rdata, cpu_rdata;
    logic        m_do_read;
    logic [23:0] m_addr;
    logic        m_next_byte, m_is_idle;
    logic [31:0] m_rdata;
    logic        grant_vid, grant_cpu;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spimem_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .vid_do_read(vid_do_read), .vid_addr(vid_addr), .vid_next_byte(vid_next_byte),
        .vid_rdata(vid_rdata), .vid_is_idle(vid_is_idle),
        .cpu_do_read(cpu_do_read), .cpu_addr(cpu_addr), .cpu_next_byte(cpu_next_byte),
        .cpu_rdata(cpu_rdata), .cpu_is_idle(cpu_is_idle),
        .m_do_read(m_do_read), .m_addr(m_addr), .m_next_byte(m_next_byte),
        .m_rdata(m_rdata), .m_is_idle(m_is_idle),
        .grant_vid(grant_vid), .grant_cpu(grant_cpu)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Owner releases, bus drains with memory idle, request optionally re-raised during DRAIN
    task automatic end_burst(input logic is_cpu, input logic reraise);
        if (is_cpu) cpu_do_read = 1'b0; else vid_do_read = 1'b0;
        tick();
        check("rel_m_do_read", m_do_read, 1'b0);
        if (reraise) begin
            if (is_cpu) cpu_do_read = 1'b1; else vid_do_read = 1'b1;
        end
        tick();
        check("rel_idle_grants", {grant_vid, grant_cpu}, 2'b00);
    endtask

    initial begin
        reset = 1'b1; vid_do_read = 0; cpu_do_read = 0;
        vid_addr = 24'h7E0000; cpu_addr = 24'h012340;
        m_next_byte = 0; m_is_idle = 1; m_rdata = 32'h0;
        tick(); tick();
        check("rst_m_do_read", m_do_read, 1'b0);
        check("rst_m_addr", m_addr, 24'h0);
        check("rst_grants", {grant_vid, grant_cpu}, 2'b00);
        check("rst_is_idle", {vid_is_idle, cpu_is_idle}, 2'b11);
        reset = 1'b0;

        // Memory busy in IDLE: request must stay pending
        m_is_idle = 0; vid_do_read = 1;
        tick(); tick();
        check("busy_no_grant", {grant_vid, grant_cpu, m_do_read}, 3'b000);
        check("busy_is_idle", {vid_is_idle, cpu_is_idle}, 2'b00);

        // Video-only burst, one cycle request-to-m_do_read
        m_is_idle = 1;
        tick();
        check("vid_grant", {grant_vid, grant_cpu}, 2'b10);
        check("vid_m_do_read", m_do_read, 1'b1);
        check("vid_m_addr", m_addr, 24'h7E0000);
        check("vid_cpu_is_idle", cpu_is_idle, 1'b0);
        check("vid_vid_is_idle", vid_is_idle, 1'b1);
        m_is_idle = 0; vid_addr = 24'h111111; cpu_do_read = 1;
        for (int i = 0; i < 16; i++) begin
            m_next_byte = 1; m_rdata = 32'hA500_0000 + i;
            #1;
            check("burst_vid_nb", vid_next_byte, 1'b1);
            check("burst_cpu_nb", cpu_next_byte, 1'b0);
            check("burst_rdata", cpu_rdata, 32'hA500_0000 + i);
            tick();
        end
        m_next_byte = 0;
        check("burst_addr_hold", m_addr, 24'h7E0000);
        check("burst_m_do_read", m_do_read, 1'b1);

        // Release, drain held by a busy controller
        vid_do_read = 0;
        tick();
        check("drain_m_do_read", m_do_read, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("drain_hold", {grant_vid, grant_cpu}, 2'b10);
        end
        m_is_idle = 1;
        tick();
        check("drain_to_idle", {grant_vid, grant_cpu}, 2'b00);
        check("idle_cpu_is_idle", cpu_is_idle, 1'b1);
        tick();
        check("cpu_grant", {grant_vid, grant_cpu}, 2'b01);
        check("cpu_m_addr", m_addr, 24'h012340);

        // Simultaneous requests with counter at 0: video first, then CPU
        vid_do_read = 1;
        end_burst(1'b1, 1'b1);
        tick();
        check("sim_vid_first", {grant_vid, grant_cpu}, 2'b10);
        m_next_byte = 1; m_is_idle = 0;
        #1;
        check("sim_cpu_nb", cpu_next_byte, 1'b0);
        check("sim_cpu_is_idle", cpu_is_idle, 1'b0);
        tick();
        check("sim_cpu_nb2", cpu_next_byte, 1'b0);
        m_next_byte = 0; m_is_idle = 1;
        end_burst(1'b0, 1'b0);
        tick();
        check("sim_cpu_after", {grant_vid, grant_cpu}, 2'b01);

        // Starvation: video wins 4, CPU wins the 5th, counter back to 0 so video wins the 6th
        vid_do_read = 1;
        end_burst(1'b1, 1'b1);
        for (int r = 1; r <= 6; r++) begin
            tick();
            check($sformatf("starve_round%0d", r), {grant_vid, grant_cpu},
                  (r == 5) ? 2'b01 : 2'b10);
            if (r < 6) end_burst(r == 5, 1'b1);
        end

        // Late byte on release, held through DRAIN, dropped in IDLE
        cpu_do_read = 0;
        vid_do_read = 0; m_next_byte = 1;
        #1;
        check("late_nb_burst", vid_next_byte, 1'b1);
        tick();
        check("late_nb_drain", vid_next_byte, 1'b1);
        check("late_m_do_read", m_do_read, 1'b0);
        tick();
        check("idle_nb_drop", {vid_next_byte, cpu_next_byte}, 2'b00);

        // Reset mid-burst
        m_next_byte = 0; vid_do_read = 1;
        tick();
        check("pre_rst_grant", grant_vid, 1'b1);
        m_next_byte = 1; reset = 1;
        tick();
        check("mid_rst_m_do_read", m_do_read, 1'b0);
        check("mid_rst_grants", {grant_vid, grant_cpu}, 2'b00);
        check("mid_rst_nb", {vid_next_byte, cpu_next_byte}, 2'b00);
        check("mid_rst_m_addr", m_addr, 24'h0);
        reset = 0; m_next_byte = 0; vid_do_read = 0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
